mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Upstream control stage for the WIDTH-bit 2:1 multiplexor.
- Arbitrates between two valid/ready producer channels with round-robin fairness.
- Registers the winning word and presents it downstream with its source select, driving the mux `sel` and `data` path.
- One-entry output stage with full-throughput pass-through: it accepts one word per cycle while downstream keeps draining.

Parameters:
- WIDTH, 5, data word width in bits for both input channels and the output.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in0_valid, input, 1, channel 0 has a word.
- in0_data, input, WIDTH, channel 0 word.
- in0_ready, output, 1, channel 0 word accepted this cycle.
- in1_valid, input, 1, channel 1 has a word.
- in1_data, input, WIDTH, channel 1 word.
- in1_ready, output, 1, channel 1 word accepted this cycle.
- out_valid, output, 1, out_data and out_sel are valid.
- out_data, output, WIDTH, registered winning word.
- out_sel, output, 1, source of out_data (0 = channel 0, 1 = channel 1); this is the mux select.
- out_ready, input, 1, downstream consumes the word when out_valid && out_ready.

Behaviour:
- Reset, asynchronous, takes effect immediately regardless of clk:
  - out_valid=0, out_data=0, out_sel=0.
  - Internal last_grant=1, so channel 0 wins the first tie.
  - A mid-transfer word held in the output register is discarded.
- Output register states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - can_load = !out_valid || out_ready (combinational).
- Grant, combinational:
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant !last_grant.
  - Neither valid: no grant.
- Ready outputs:
  - in0_ready = can_load && grant==0 && in0_valid.
  - in1_ready = can_load && grant==1 && in1_valid.
  - At most one ready is high in any cycle. Ready never depends on rst being released mid-cycle.
- On the clock edge when a grant exists and can_load:
  - out_data <= granted data.
  - out_sel <= grant.
  - out_valid <= 1.
  - last_grant <= grant.
- On the clock edge when out_valid && out_ready and no grant: out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge, giving 1 word/cycle sustained.
- Backpressure: while out_valid && !out_ready, out_data and out_sel stay stable and both readys are 0. Inputs must hold valid/data until their ready is seen.
- Latency: an accepted word appears on out_data one clock after its ready cycle.
- last_grant updates only on an actual transfer, never on a stalled request.
- Fairness: with both channels continuously valid and out_ready=1, grants alternate 0,1,0,1, ...
- Data passes through unmodified. No width conversion and no arithmetic.

Test Plan:
1. Reset with out_ready=1, in0_valid=1, in0_data=5'h15, in1_valid=0; release rst:
   - in0_ready=1 in the first cycle.
   - Next cycle out_valid=1, out_data=5'h15, out_sel=0.
2. Both valid (in0_data=5'h15, in1_data=5'h0A), out_ready=1 for 4 cycles:
   - out_sel sequence 0,1,0,1.
   - out_data sequence 15,0A,15,0A.
   - Exactly one ready per cycle.
3. Word 5'h0A loaded from ch1, then out_ready=0 for 3 cycles with both inputs valid:
   - out_data holds 5'h0A and out_sel holds 1.
   - in0_ready=in1_ready=0 throughout.
   - On out_ready=1, the next load is ch0.
4. Load 5'h15, then drop both valids with out_ready=1:
   - out_valid falls one cycle later.
   - out_data remains 5'h15.
5. Assert rst asynchronously between clock edges while out_valid=1, out_data=5'h0A:
   - out_valid=0, out_data=0, out_sel=0 immediately, without waiting for a clock edge.
   - After release, a tie grants channel 0 first.
6. Only in1_valid for 3 consecutive transfers (5'h01, 5'h02, 5'h03):
   - All are granted to ch1 with out_sel=1.
   - A following tie grants ch0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Two-channel valid/ready round-robin arbiter feeding a one-entry output register
// that drives the downstream 2:1 mux select and data path.
module mux_rr_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             last_grant_q, last_grant_d;

  logic             can_load;
  logic             grant_vld;
  logic             grant;
  logic             load;

  // A tie goes to the channel that did not win the previous transfer.
  always_comb begin
    grant_vld = in0_valid | in1_valid;
    grant     = 1'b0;
    if (in0_valid && in1_valid) begin
      grant = ~last_grant_q;
    end else if (in1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_load  = (state_q == EMPTY) || out_ready;
  assign load      = can_load && grant_vld;
  assign in0_ready = load && !grant && in0_valid;
  assign in1_ready = load &&  grant && in1_valid;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      EMPTY: begin
        if (load) begin
          state_d      = FULL;
          data_d       = grant ? in1_data : in0_data;
          sel_d        = grant;
          last_grant_d = grant;
        end
      end
      FULL: begin
        // Drain and refill in the same edge keeps one word per cycle.
        if (load) begin
          data_d       = grant ? in1_data : in0_data;
          sel_d        = grant;
          last_grant_d = grant;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized bench for mux_rr_arbiter against a transaction-level model.
module tb_mux_rr_arbiter;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  int vectors;
  int miscompares;

  // Model of the visible output word plus who was served most recently.
  bit m_valid;
  int m_data;
  int m_sel;
  int m_last;

  bit acc0;
  bit acc1;

  mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_last  = 1;
  endtask

  // Winner by the arbitration rules; -1 when nobody requests.
  function automatic int winner(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Called on the falling edge with inputs already applied; returns on the next falling edge.
  task automatic cycle(input string tag);
    int  w;
    bit  room;
    bit  e0;
    bit  e1;
    int  d0;
    int  d1;
    #1;
    room = !m_valid || out_ready;
    w    = winner(in0_valid, in1_valid, m_last);
    e0   = room && (w == 0);
    e1   = room && (w == 1);
    d0   = int'(in0_data);
    d1   = int'(in1_data);
    chk({tag, ".in0_ready"}, in0_ready, e0);
    chk({tag, ".in1_ready"}, in1_ready, e1);
    acc0 = in0_ready;
    acc1 = in1_ready;
    @(posedge clk);
    #1;
    if (room && w >= 0) begin
      m_valid = 1;
      m_data  = (w == 0) ? d0 : d1;
      m_sel   = w;
      m_last  = w;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".out_data"},  out_data,  m_data);
    chk({tag, ".out_sel"},   out_sel,   m_sel);
    @(negedge clk);
  endtask

  task automatic drive(input bit v0, input int d0, input bit v1, input int d1, input bit ordy);
    in0_valid = v0;
    in0_data  = d0[WIDTH-1:0];
    in1_valid = v1;
    in1_data  = d1[WIDTH-1:0];
    out_ready = ordy;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    acc0        = 0;
    acc1        = 0;
    model_reset();

    // Test 1: reset state, then a single ch0 word
    rst = 1'b1;
    drive(1, 'h15, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_data",  out_data,  5'h00);
    chk("rst.out_sel",   out_sel,   1'b0);
    rst = 1'b0;
    cycle("t1");
    chk("t1.data_lit", out_data, 5'h15);

    // Test 2: tie from fresh reset alternates 0,1,0,1
    reset_pulse();
    drive(1, 'h15, 1, 'h0A, 1);
    cycle("t2a"); chk("t2a.sel_lit", out_sel, 1'b0); chk("t2a.data_lit", out_data, 5'h15);
    cycle("t2b"); chk("t2b.sel_lit", out_sel, 1'b1); chk("t2b.data_lit", out_data, 5'h0A);
    cycle("t2c"); chk("t2c.sel_lit", out_sel, 1'b0); chk("t2c.data_lit", out_data, 5'h15);
    cycle("t2d"); chk("t2d.sel_lit", out_sel, 1'b1); chk("t2d.data_lit", out_data, 5'h0A);

    // Test 3: backpressure holds 0A from ch1, then ch0 wins
    drive(1, 'h15, 1, 'h0A, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("t3.stall");
      chk("t3.hold_data", out_data, 5'h0A);
      chk("t3.hold_sel",  out_sel,  1'b1);
    end
    out_ready = 1'b1;
    cycle("t3.resume");
    chk("t3.resume_sel", out_sel, 1'b0);

    // Test 4: drain after last word, data persists
    drive(1, 'h15, 0, 0, 1);
    cycle("t4.load");
    drive(0, 0, 0, 0, 1);
    cycle("t4.drain");
    chk("t4.valid_lit", out_valid, 1'b0);
    chk("t4.data_lit",  out_data,  5'h15);

    // Test 5: asynchronous reset between edges discards a held word
    drive(0, 0, 1, 'h0A, 1);
    cycle("t5.load");
    drive(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5.async_valid", out_valid, 1'b0);
    chk("t5.async_data",  out_data,  5'h00);
    chk("t5.async_sel",   out_sel,   1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 'h15, 1, 'h0A, 1);
    cycle("t5.tie");
    chk("t5.tie_sel", out_sel, 1'b0);

    // Test 6: ch1-only stream, then a tie goes to ch0
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, i, 1);
      cycle("t6.ch1");
      chk("t6.sel_lit",  out_sel,  1'b1);
      chk("t6.data_lit", out_data, 32'(i));
    end
    drive(1, 'h15, 1, 'h0A, 1);
    cycle("t6.tie");
    chk("t6.tie_sel", out_sel, 1'b0);

    // Randomized traffic; producers hold a word until it is accepted
    drive(0, 0, 0, 0, 1);
    acc0 = 1;
    acc1 = 1;
    for (int n = 0; n < 400; n++) begin
      if (!in0_valid || acc0) begin
        in0_valid = ($urandom_range(0, 3) != 0);
        in0_data  = WIDTH'($urandom);
      end
      if (!in1_valid || acc1) begin
        in1_valid = ($urandom_range(0, 3) != 0);
        in1_data  = WIDTH'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (n == 200) begin
        reset_pulse();
      end
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
